// File: rtl/wash_pkg.sv
// wash_pkg: phase encodings and phase-length lookup shared by the wash sequencer.
package wash_pkg;
    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4
    } phase_t;

    // Minutes a phase lasts, selected from the caller's per-phase durations.
    function automatic int phase_len(phase_t p, int fill_min, int wash_min, int rinse_min, int spin_min);
        return p == PH_FILL  ? fill_min  :
               p == PH_WASH  ? wash_min  :
               p == PH_RINSE ? rinse_min :
               p == PH_SPIN  ? spin_min  : 1;
    endfunction
endpackage

// File: rtl/wash_sequencer_multi_tick.sv
// minute_tick_gen: prescaler producing a one-cycle tick every (TICKS_BASE << clk_freq) cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count from zero (phase entry / idle)
//   hold       : freeze the count and suppress the tick (spin pause)
//   clk_freq   : clock setting, scales the tick length by 1/2/4/8
//   tick       : high on the last cycle of each minute
module minute_tick_gen #(
    parameter int TICKS_BASE = 60_000_000,
    parameter int CNT_WIDTH  = 29
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       hold,
    input  logic [1:0] clk_freq,
    output logic       tick
);
    logic [CNT_WIDTH-1:0] cnt, last;

    assign last = (CNT_WIDTH'(TICKS_BASE) << clk_freq) - 1'b1;
    assign tick = !hold && cnt == last;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (!hold)
            cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/wash_sequencer_multi.sv
// wash_sequencer_multi: coin-started washing programme of N fill/wash/rinse passes plus one spin.
//   clk, rst_n       : clock, asynchronous active-low reset
//   coin_in          : start request, accepted only when idle
//   pass_sel         : requested passes (0 -> 1, above MAX_PASSES saturates), latched at coin
//   clk_freq         : clock setting 0..3 (1/2/4/8 MHz), latched at coin
//   timer_pause      : freezes the spin phase timer
//   abort            : synchronous cancel back to idle
//   phase, pass_idx, minutes_in_phase, busy, wash_done : registered status
module wash_sequencer_multi
    import wash_pkg::*;
#(
    parameter int TICKS_BASE = 60_000_000,
    parameter int CNT_WIDTH  = 29,
    parameter int MIN_WIDTH  = 4,
    parameter int FILL_MIN   = 2,
    parameter int WASH_MIN   = 5,
    parameter int RINSE_MIN  = 2,
    parameter int SPIN_MIN   = 1,
    parameter int MAX_PASSES = 4,
    parameter int PASS_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  coin_in,
    input  logic [PASS_WIDTH-1:0] pass_sel,
    input  logic [1:0]            clk_freq,
    input  logic                  timer_pause,
    input  logic                  abort,
    output logic [PHASE_W-1:0]    phase,
    output logic [PASS_WIDTH-1:0] pass_idx,
    output logic [MIN_WIDTH-1:0]  minutes_in_phase,
    output logic                  busy,
    output logic                  wash_done
);
    phase_t                state, state_d;
    logic [PASS_WIDTH-1:0] passes, passes_d, pass_d, pass_sat;
    logic [MIN_WIDTH-1:0]  min_d;
    logic [1:0]            freq, freq_d;
    logic                  done_d, tick, clr, hold, phase_end, more;

    assign phase     = state;
    assign hold      = state == PH_SPIN && timer_pause;
    assign phase_end = tick && int'(minutes_in_phase) == phase_len(state, FILL_MIN, WASH_MIN, RINSE_MIN, SPIN_MIN) - 1;
    assign more      = pass_idx < passes - 1'b1;
    assign pass_sat  = pass_sel == '0 ? PASS_WIDTH'(1) :
                       pass_sel > PASS_WIDTH'(MAX_PASSES) ? PASS_WIDTH'(MAX_PASSES) : pass_sel;

    minute_tick_gen #(
        .TICKS_BASE(TICKS_BASE),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .hold    (hold),
        .clk_freq(freq),
        .tick    (tick)
    );

    // Abort outranks everything; the prescaler is held clear while idle so every
    // phase entry starts a fresh minute.
    always_comb begin
        state_d  = state;
        pass_d   = pass_idx;
        min_d    = minutes_in_phase;
        done_d   = wash_done;
        passes_d = passes;
        freq_d   = freq;
        clr      = 1'b0;
        if (abort) begin
            state_d = PH_IDLE;
            pass_d  = '0;
            min_d   = '0;
            done_d  = 1'b0;
            clr     = 1'b1;
        end else if (state == PH_IDLE) begin
            clr = 1'b1;
            if (coin_in) begin
                state_d  = PH_FILL;
                pass_d   = '0;
                done_d   = 1'b0;
                passes_d = pass_sat;
                freq_d   = clk_freq;
            end
        end else if (phase_end) begin
            clr     = 1'b1;
            min_d   = '0;
            state_d = state == PH_FILL  ? PH_WASH :
                      state == PH_WASH  ? PH_RINSE :
                      state == PH_RINSE ? (more ? PH_FILL : PH_SPIN) : PH_IDLE;
            pass_d  = state == PH_RINSE && more ? pass_idx + 1'b1 : pass_idx;
            done_d  = wash_done | (state == PH_SPIN);
        end else if (tick) begin
            min_d = minutes_in_phase + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state            <= PH_IDLE;
            pass_idx         <= '0;
            minutes_in_phase <= '0;
            busy             <= 1'b0;
            wash_done        <= 1'b0;
            passes           <= '0;
            freq             <= '0;
        end else begin
            state            <= state_d;
            pass_idx         <= pass_d;
            minutes_in_phase <= min_d;
            busy             <= state_d != PH_IDLE;
            wash_done        <= done_d;
            passes           <= passes_d;
            freq             <= freq_d;
        end
endmodule

// File: tb/tb_wash_sequencer_multi.sv
// tb_wash_sequencer_multi: directed timing scenarios plus random stimulus against a cycle-count model.
module tb_wash_sequencer_multi;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_in = 1'b0;
    logic [2:0] pass_sel = 3'd1;
    logic [1:0] clk_freq = 2'd0;
    logic       timer_pause = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] phase;
    logic [2:0] pass_idx;
    logic [3:0] minutes_in_phase;
    logic       busy;
    logic       wash_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    wash_sequencer_multi #(
        .TICKS_BASE(4), .CNT_WIDTH(6), .MIN_WIDTH(4),
        .FILL_MIN(2), .WASH_MIN(3), .RINSE_MIN(2), .SPIN_MIN(1),
        .MAX_PASSES(4), .PASS_WIDTH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .pass_sel(pass_sel),
        .clk_freq(clk_freq), .timer_pause(timer_pause), .abort(abort),
        .phase(phase), .pass_idx(pass_idx), .minutes_in_phase(minutes_in_phase),
        .busy(busy), .wash_done(wash_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Model: a phase is tracked as cycles elapsed since entry (paused cycles excluded);
    // it ends after len*tick_len cycles and minutes are elapsed/tick_len.
    int m_ph = 0, m_pass = 0, m_e = 0, m_done = 0, m_np = 1, m_tl = 4;

    function automatic int plen(int p);
        return p == 1 ? 2 : p == 2 ? 3 : p == 3 ? 2 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_pass = 0; m_e = 0; m_done = 0; m_np = 1; m_tl = 4;
        end else if (abort) begin
            m_ph = 0; m_pass = 0; m_e = 0; m_done = 0;
        end else if (m_ph == 0) begin
            if (coin_in) begin
                m_ph = 1; m_pass = 0; m_done = 0; m_e = 0;
                m_np = pass_sel == 0 ? 1 : pass_sel > 4 ? 4 : int'(pass_sel);
                m_tl = 4 << clk_freq;
            end
        end else if (!(m_ph == 4 && timer_pause)) begin
            m_e++;
            if (m_e == plen(m_ph) * m_tl) begin
                m_e = 0;
                if (m_ph == 3) begin
                    if (m_pass < m_np - 1) begin m_ph = 1; m_pass++; end
                    else m_ph = 4;
                end else if (m_ph == 4) begin
                    m_ph = 0; m_done = 1;
                end else m_ph++;
            end
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_n) begin
            tests++;
            if (phase !== 3'(m_ph) || pass_idx !== 3'(m_pass) || minutes_in_phase !== 4'(m_e / m_tl) ||
                busy !== (m_ph != 0) || wash_done !== 1'(m_done)) begin
                fails++;
                $display("FAIL model cyc %0d: phase/pass/min/busy/done got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                         cyc, phase, pass_idx, minutes_in_phase, busy, wash_done,
                         m_ph, m_pass, m_e / m_tl, m_ph != 0, m_done);
            end
        end

    task automatic prog(input string nm, input int ps, input int fr, input int exp_fill, input int exp_spin,
                        input int exp_done, input int pause_len, input bit hold_coin, input bit noise);
        int start, fill_t, spin_t, pc, n;
        @(negedge clk);
        pass_sel = 3'(ps); clk_freq = 2'(fr); coin_in = 1'b1;
        @(posedge clk);
        #1 start = cyc;
        coin_in = hold_coin;
        fill_t = -1; spin_t = -1; pc = 0; n = 0;
        while (!wash_done && n < 3000) begin
            @(negedge clk);
            n++;
            if (fill_t < 0 && phase != 3'd1) fill_t = cyc - start;
            if (spin_t < 0 && phase == 3'd4) spin_t = cyc - start;
            if (noise) begin
                clk_freq = 2'($urandom);
                pass_sel = 3'($urandom);
            end
            timer_pause = phase == 3'd4 ? (pc < pause_len) : (noise ? 1'($urandom) : 1'b0);
            if (phase == 3'd4 && pc < pause_len) pc++;
        end
        coin_in = 1'b0;
        timer_pause = 1'b0;
        check({nm, " fill"}, fill_t, exp_fill);
        check({nm, " spin"}, spin_t, exp_spin);
        check({nm, " done"}, cyc - start, exp_done);
        @(negedge clk);
        check({nm, " idle after"}, int'(phase), 0);
    endtask

    task automatic wait_phase(input int p, input int m);
        int n = 0;
        while (!(phase == 3'(p) && minutes_in_phase == 4'(m)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait phase", int'(phase), p);
    endtask

    initial begin
        #1;
        check("reset phase", int'(phase), 0);
        check("reset busy/done", int'({busy, wash_done}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        prog("p1", 1, 0, 8, 28, 32, 0, 1'b0, 1'b0);
        prog("p2", 2, 0, 8, 56, 60, 0, 1'b0, 1'b0);
        prog("f3", 1, 3, 64, 224, 256, 0, 1'b0, 1'b1);
        prog("pause", 1, 0, 8, 28, 42, 10, 1'b0, 1'b0);

        // abort during WASH minute 1
        @(negedge clk);
        pass_sel = 3'd1; clk_freq = 2'd0; coin_in = 1'b1;
        @(negedge clk);
        coin_in = 1'b0;
        wait_phase(2, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort phase", int'(phase), 0);
        check("abort busy/done", int'({busy, wash_done}), 0);
        prog("restart", 1, 0, 8, 28, 32, 0, 1'b0, 1'b0);

        // coin together with abort in idle
        @(negedge clk);
        coin_in = 1'b1; abort = 1'b1;
        @(negedge clk);
        coin_in = 1'b0; abort = 1'b0;
        check("coin+abort idle", int'(phase), 0);

        prog("hold coin", 1, 0, 8, 28, 32, 0, 1'b1, 1'b0);
        prog("ps0", 0, 0, 8, 28, 32, 0, 1'b0, 1'b0);
        prog("ps7", 7, 0, 8, 112, 116, 0, 1'b0, 1'b0);

        // asynchronous reset mid-SPIN
        @(negedge clk);
        pass_sel = 3'd1; coin_in = 1'b1;
        @(negedge clk);
        coin_in = 1'b0;
        wait_phase(4, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst phase", int'(phase), 0);
        check("rst pass/min", int'({pass_idx, minutes_in_phase}), 0);
        check("rst busy/done", int'({busy, wash_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4000) begin
            @(negedge clk);
            coin_in     = $urandom_range(0, 3) == 0;
            abort       = $urandom_range(0, 199) == 0;
            timer_pause = 1'($urandom);
            pass_sel    = 3'($urandom);
            clk_freq    = 2'($urandom);
        end
        abort = 1'b0; coin_in = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
